// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core clocked by clk with tick1Hz/tick2Hz clock enables.
// Optional countdown (countDown port) is enabled by defining STOPWATCH_COUNTDOWN_EN.
module stopwatch_counter #(
  parameter int MIN_LIMIT = 59,
  parameter int SEC_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick1Hz,
  input  logic       tick2Hz,
  input  logic       isAdj,
  input  logic       adjSel,
  input  logic       pause,
  input  logic       clear,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic       countDown,
`endif
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [2:0] sec10,
  output logic [3:0] sec1,
  output logic       rollover,
  output logic       blink
);

  localparam logic [3:0] MIN_LIM_T = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_LIM_U = 4'(MIN_LIMIT % 10);
  localparam logic [2:0] SEC_LIM_T = 3'(SEC_LIMIT / 10);
  localparam logic [3:0] SEC_LIM_U = 4'(SEC_LIMIT % 10);

  logic       sec_at_lim, min_at_lim;
  logic [3:0] sec1_inc, min1_inc, min10_inc;
  logic [2:0] sec10_inc;

  logic [3:0] min10_d, min1_d, sec1_d;
  logic [2:0] sec10_d;
  logic       roll_d, blink_d;

  // Limits compare on the full two-digit value, so a field never passes its limit.
  assign sec_at_lim = (sec10 == SEC_LIM_T) && (sec1 == SEC_LIM_U);
  assign min_at_lim = (min10 == MIN_LIM_T) && (min1 == MIN_LIM_U);

  assign sec1_inc  = (sec_at_lim || sec1 == 4'd9) ? 4'd0 : sec1 + 4'd1;
  assign sec10_inc = sec_at_lim ? 3'd0 : ((sec1 == 4'd9) ? sec10 + 3'd1 : sec10);
  assign min1_inc  = (min_at_lim || min1 == 4'd9) ? 4'd0 : min1 + 4'd1;
  assign min10_inc = min_at_lim ? 4'd0 : ((min1 == 4'd9) ? min10 + 4'd1 : min10);

`ifdef STOPWATCH_COUNTDOWN_EN
  logic       sec_zero, min_zero;
  logic [3:0] sec1_dec, min1_dec, min10_dec;
  logic [2:0] sec10_dec;

  assign sec_zero  = (sec10 == 3'd0) && (sec1 == 4'd0);
  assign min_zero  = (min10 == 4'd0) && (min1 == 4'd0);
  assign sec1_dec  = sec_zero ? SEC_LIM_U : ((sec1 == 4'd0) ? 4'd9 : sec1 - 4'd1);
  assign sec10_dec = sec_zero ? SEC_LIM_T : ((sec1 == 4'd0) ? sec10 - 3'd1 : sec10);
  // Only used when minutes are non-zero; 00:00 holds instead of borrowing.
  assign min1_dec  = (min1 == 4'd0) ? 4'd9 : min1 - 4'd1;
  assign min10_dec = (min1 == 4'd0) ? min10 - 4'd1 : min10;
`endif

  always_comb begin
    min10_d = min10;
    min1_d  = min1;
    sec10_d = sec10;
    sec1_d  = sec1;
    roll_d  = 1'b0;
    blink_d = blink;
    if (clear) begin
      min10_d = 4'd0;
      min1_d  = 4'd0;
      sec10_d = 3'd0;
      sec1_d  = 4'd0;
      blink_d = 1'b0;
    end else if (isAdj) begin
      if (tick2Hz) begin
        blink_d = ~blink;
        if (adjSel) begin
          sec10_d = sec10_inc;
          sec1_d  = sec1_inc;
        end else begin
          min10_d = min10_inc;
          min1_d  = min1_inc;
        end
      end
    end else begin
      blink_d = 1'b0;
      if (tick1Hz && !pause) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (countDown) begin
          if (!(sec_zero && min_zero)) begin
            sec10_d = sec10_dec;
            sec1_d  = sec1_dec;
            if (sec_zero) begin
              min10_d = min10_dec;
              min1_d  = min1_dec;
            end
            roll_d = min_zero && (sec10 == 3'd0) && (sec1 == 4'd1);
          end
        end else begin
`else
        begin
`endif
          sec10_d = sec10_inc;
          sec1_d  = sec1_inc;
          if (sec_at_lim) begin
            min10_d = min10_inc;
            min1_d  = min1_inc;
            roll_d  = min_at_lim;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min10    <= 4'd0;
      min1     <= 4'd0;
      sec10    <= 3'd0;
      sec1     <= 4'd0;
      rollover <= 1'b0;
      blink    <= 1'b0;
    end else begin
      min10    <= min10_d;
      min1     <= min1_d;
      sec10    <= sec10_d;
      sec1     <= sec1_d;
      rollover <= roll_d;
      blink    <= blink_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: default limits plus a SEC_LIMIT=9 / MIN_LIMIT=99 copy.
module tb_stopwatch_counter;

  logic clk, rst_n, tick1Hz, tick2Hz, isAdj, adjSel, pause, clear;
  logic countDown;
  logic [3:0] min10, min1, sec1;
  logic [2:0] sec10;
  logic rollover, blink;
  logic [3:0] b_min10, b_min1, b_sec1;
  logic [2:0] b_sec10;
  logic b_rollover, b_blink;

  int nchk = 0;
  int nerr = 0;

  stopwatch_counter u_dut (
    .clk(clk), .rst_n(rst_n), .tick1Hz(tick1Hz), .tick2Hz(tick2Hz),
    .isAdj(isAdj), .adjSel(adjSel), .pause(pause), .clear(clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .countDown(countDown),
`endif
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .rollover(rollover), .blink(blink)
  );

  stopwatch_counter #(.MIN_LIMIT(99), .SEC_LIMIT(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .tick1Hz(tick1Hz), .tick2Hz(tick2Hz),
    .isAdj(isAdj), .adjSel(adjSel), .pause(pause), .clear(clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .countDown(countDown),
`endif
    .min10(b_min10), .min1(b_min1), .sec10(b_sec10), .sec1(b_sec1),
    .rollover(b_rollover), .blink(b_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tval();
    return {min10, min1, 1'b0, sec10, sec1};
  endfunction

  function automatic logic [15:0] tval9();
    return {b_min10, b_min1, 1'b0, b_sec10, b_sec1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t1, input logic t2);
    tick1Hz = t1;
    tick2Hz = t2;
    @(posedge clk);
    #1;
    tick1Hz = 1'b0;
    tick2Hz = 1'b0;
  endtask

  task automatic adj(input logic sel, input int n);
    isAdj  = 1'b1;
    adjSel = sel;
    repeat (n) step(1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; tick1Hz = 1'b0; tick2Hz = 1'b0; isAdj = 1'b0;
    adjSel = 1'b0; pause = 1'b0; clear = 1'b0; countDown = 1'b0;
    #3;
    chk("reset_time", 32'(tval()), 32'h0000);
    chk("reset_roll", 32'(rollover), 32'h0);
    #9 rst_n = 1'b1;

    // Load 12:34 through adjust, then reset asynchronously mid-cycle
    adj(1'b0, 12);
    adj(1'b1, 34);
    isAdj = 1'b0;
    step(1'b0, 1'b0);
    chk("preload_1234", 32'(tval()), 32'h1234);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_time", 32'(tval()), 32'h0000);
    chk("async_rst_roll", 32'(rollover), 32'h0);
    chk("async_rst_blink", 32'(blink), 32'h0);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_hold", 32'(tval()), 32'h0000);
    step(1'b1, 1'b0);
    chk("first_tick", 32'(tval()), 32'h0001);

    // Pause drops ticks, clear beats tick1Hz
    repeat (9) step(1'b1, 1'b0);
    chk("count_0010", 32'(tval()), 32'h0010);
    pause = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    chk("pause_hold", 32'(tval()), 32'h0010);
    pause = 1'b0;
    step(1'b1, 1'b0);
    chk("no_queue", 32'(tval()), 32'h0011);
    step(1'b0, 1'b1);
    chk("tick2_ignored", 32'(tval()), 32'h0011);
    chk("blink_normal", 32'(blink), 32'h0);
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
    chk("clear_time", 32'(tval()), 32'h0000);
    chk("clear_roll", 32'(rollover), 32'h0);
    chk("clear_time9", 32'(tval9()), 32'h0000);

    // Seconds carry; the SEC_LIMIT=9 copy lands on 00:09 after the same 59 adjust ticks
    adj(1'b1, 59);
    chk("adj_0059", 32'(tval()), 32'h0059);
    chk("adj9_0009", 32'(tval9()), 32'h0009);
    chk("blink_odd", 32'(blink), 32'h1);
    isAdj = 1'b0;
    step(1'b0, 1'b0);
    chk("blink_exit", 32'(blink), 32'h0);
    step(1'b1, 1'b0);
    chk("carry_0100", 32'(tval()), 32'h0100);
    chk("carry_roll", 32'(rollover), 32'h0);
    chk("carry9_0100", 32'(tval9()), 32'h0100);
    chk("carry9_roll", 32'(b_rollover), 32'h0);

    // Adjust seconds with wrap, tick1Hz driven alongside
    adj(1'b0, 4);
    adj(1'b1, 58);
    chk("adj_0558", 32'(tval()), 32'h0558);
    chk("adj_blink0", 32'(blink), 32'h0);
    step(1'b1, 1'b1);
    chk("adj_0559", 32'(tval()), 32'h0559);
    chk("adj_blink1", 32'(blink), 32'h1);
    step(1'b1, 1'b1);
    chk("adj_wrap_0500", 32'(tval()), 32'h0500);
    chk("adj_wrap_roll", 32'(rollover), 32'h0);
    chk("adj_blink2", 32'(blink), 32'h0);
    step(1'b1, 1'b1);
    chk("adj_0501", 32'(tval()), 32'h0501);
    chk("adj_blink3", 32'(blink), 32'h1);
    step(1'b1, 1'b0);
    chk("adj_t1_ignored", 32'(tval()), 32'h0501);

    // Full wrap with rollover pulse
    adj(1'b0, 54);
    adj(1'b1, 57);
    chk("adj_5958", 32'(tval()), 32'h5958);
    isAdj = 1'b0;
    step(1'b1, 1'b0);
    chk("wrap_5959", 32'(tval()), 32'h5959);
    chk("wrap_roll_pre", 32'(rollover), 32'h0);
    step(1'b1, 1'b0);
    chk("wrap_0000", 32'(tval()), 32'h0000);
    chk("wrap_roll", 32'(rollover), 32'h1);
    step(1'b0, 1'b0);
    chk("wrap_roll_1cyc", 32'(rollover), 32'h0);
    chk("wrap_hold", 32'(tval()), 32'h0000);

`ifdef STOPWATCH_COUNTDOWN_EN
    adj(1'b0, 1);
    isAdj = 1'b0;
    countDown = 1'b1;
    step(1'b1, 1'b0);
    chk("cd_0059", 32'(tval()), 32'h0059);
    adj(1'b1, 2);
    chk("cd_adj_0001", 32'(tval()), 32'h0001);
    isAdj = 1'b0;
    step(1'b1, 1'b0);
    chk("cd_0000", 32'(tval()), 32'h0000);
    chk("cd_roll", 32'(rollover), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("cd_hold", 32'(tval()), 32'h0000);
      chk("cd_hold_roll", 32'(rollover), 32'h0);
    end
    countDown = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Parametrised MM:SS stopwatch core. It replaces the earlier two-clock counter with a single-clock design driven by clock-enable ticks.
- Counts in BCD directly, with configurable minute and second limits, pause, synchronous clear, an adjust mode, a rollover pulse and a blink phase for the display.
- Sits between the tick divider and the seven-segment multiplexer.

Parameters:
- MIN_LIMIT, 59, highest minute value before wrap; legal range 1..99.
- SEC_LIMIT, 59, highest second value before wrap; legal range 1..59.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick1Hz  input  1  one-cycle enable pulse, normal count rate
- tick2Hz  input  1  one-cycle enable pulse, adjust rate and blink rate
- isAdj  input  1  1 = adjust mode, 0 = normal mode
- adjSel  input  1  field to adjust: 0 = minutes, 1 = seconds
- pause  input  1  level; 1 freezes normal counting
- clear  input  1  synchronous clear to 00:00
- min10  output  4  minutes tens digit, BCD
- min1  output  4  minutes units digit, BCD
- sec10  output  3  seconds tens digit, BCD
- sec1  output  4  seconds units digit, BCD
- rollover  output  1  one-cycle pulse on wrap to 00:00
- blink  output  1  display blink phase

Behaviour:
- Reset: rst_n low sets all digits to 0, rollover to 0 and blink to 0 immediately, without waiting for a clock edge. Reset may be asserted mid-count and has no other effect.
- All outputs are registered. Each output updates on the clk edge where the qualifying tick is sampled high, so latency is 1 cycle.
- Priority, per cycle: clear > adjust mode > pause > normal count.
- clear: digits go to 00:00 on the next edge. blink is forced to 0. rollover is not pulsed.
- Normal mode (isAdj=0, pause=0), on tick1Hz:
  - seconds increment in BCD.
  - When seconds = SEC_LIMIT they wrap to 00 and carry into minutes.
  - When minutes = MIN_LIMIT and a carry arrives, minutes wrap to 00 and rollover pulses high for exactly that cycle.
  - tick2Hz is ignored.
- Pause (isAdj=0, pause=1): digits hold. Ticks that arrive while paused are dropped, not queued.
- Adjust mode (isAdj=1), on tick2Hz:
  - The field chosen by adjSel increments by 1.
  - It wraps from its limit to 00 with no carry into the other field and no rollover pulse.
  - The other field holds.
  - tick1Hz and pause are ignored.
- blink:
  - Toggles on each tick2Hz while isAdj=1.
  - Forced to 0 on the cycle after isAdj falls.
- Mode change: a change of isAdj or adjSel takes effect on the same edge it is sampled. No partial-tick state exists.
- Simultaneous tick1Hz and tick2Hz: only the tick that is relevant to the current mode acts.
- BCD rules:
  - A units digit wraps from 9 to 0 and increments its tens digit.
  - A field compare against its limit uses the full two-digit value.
  - Digits never hold a value above 9, and no field ever exceeds its limit.
- Limit examples:
  - MIN_LIMIT=99: min10 reaches 9.
  - SEC_LIMIT=9: sec10 stays 0.

Optional Feature:
- Macro: STOPWATCH_COUNTDOWN_EN.
- When defined:
  - Adds input port countDown (1 bit). It is only meaningful in normal mode.
  - With countDown=1, each tick1Hz decrements the count.
  - Seconds at 00 borrow from minutes and reload SEC_LIMIT.
  - On the tick that reaches 00:00, rollover pulses for 1 cycle. The count then holds at 00:00 and further ticks are ignored until clear, an adjust, or countDown=0.
  - Adjust mode is unchanged and always increments.
- When not defined: the port does not exist and the block only counts up.

Test Plan:
- Reset: assert rst_n=0 mid-count at 12:34 without a clk edge → all digits 0, rollover=0 and blink=0 at once; they hold after release until the first tick1Hz, which gives 00:01.
- Wrap and rollover (defaults): preload to 59:58 through adjust, then give 2 tick1Hz → 59:59, then 00:00 with rollover high for exactly 1 cycle.
- Carry: at 00:59 give tick1Hz → 01:00 with no rollover. With SEC_LIMIT=9 at 00:09, tick1Hz → 01:00.
- Adjust: isAdj=1, adjSel=1, start 05:58, give 3 tick2Hz → 05:59, 05:00, 05:01 with minutes unchanged, blink toggling 1,0,1. Drive tick1Hz concurrently → no effect.
- Pause and clear: pause=1 for 5 tick1Hz at 00:10 → stays 00:10. Then clear together with tick1Hz → 00:00 with no rollover.
- With STOPWATCH_COUNTDOWN_EN: countDown=1 from 01:00 → 00:59 after 1 tick. From 00:01 → 00:00 with rollover pulse, and 3 more ticks keep 00:00 with no further pulse.
